pcileech_com_tx_arbiter: RTL and testbench
==========================================

Name: pcileech_com_tx_arbiter

Overview:
- Packet-atomic round-robin arbiter that shares the single 32-bit COM transmit path (FIFO CTL -> COM CTL -> FT601) among up to four word-stream requesters, e.g. TLP, CFG, core status and shadow config.
- Sits in the clk (100 MHz) domain between the requester FIFOs and the COM TX interface.
- Adds a one-stage registered output, tags each word with its source, and detects requesters that stall mid-packet.

Parameters:
- NUM_REQ, 3, number of requesters; legal range 1..4.
- TIMEOUT_CYCLES, 1024, consecutive mid-packet cycles with granted valid low before a forced packet end; 0 disables the timeout.
- ABORT_WORD, 32'hDEADBEEF, data word emitted on a timeout-forced packet end.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester word valid.
- req_data  in  32*NUM_REQ  per-requester word; requester i uses bits [32*i+31:32*i].
- req_last  in  NUM_REQ  per-requester end-of-packet marker on the current word.
- req_ready  out  NUM_REQ  per-requester word accepted this cycle.
- tx_valid  out  1  output word valid.
- tx_data  out  32  output word.
- tx_last  out  1  output end-of-packet.
- tx_tag  out  2  index of the source requester of the current word.
- tx_abort  out  1  current word is a timeout-forced ABORT_WORD.
- tx_ready  in  1  downstream accepts the word.
- err_timeout  out  NUM_REQ  sticky per-requester timeout flags.
- err_clear  in  1  clears err_timeout (1-cycle pulse).

Behaviour:
- Reset: asynchronous assert and synchronous-release safe. All outputs go to 0, state to IDLE, round-robin pointer to 0, timeout counter to 0.
- Output register: loads when out_free = !tx_valid || tx_ready. tx_* hold stable while tx_valid && !tx_ready.
- A transfer occurs when tx_valid && tx_ready.
- States:
  - IDLE: no grant is held. Each cycle, pick the first requester with req_valid=1, searching from ptr, ptr+1 ... modulo NUM_REQ. A hit sets grant=i and moves to BUSY in the next cycle. No word is accepted in the IDLE cycle itself, so arbitration latency is 1 cycle.
  - BUSY: req_ready[grant] = req_valid[grant] && out_free; all other req_ready bits are 0.
    - On an accepted word, register data, last and tag=grant.
    - If last=1, set ptr=(grant+1) mod NUM_REQ and return to IDLE.
    - Back-to-back packets from different requesters therefore have a 1-cycle bubble.
  - Timeout counter:
    - Increments in BUSY while req_valid[grant]=0.
    - Resets to 0 on any accepted word and on entering BUSY.
    - Stalls caused by downstream backpressure do not count.
    - When the counter reaches TIMEOUT_CYCLES and out_free=1: emit ABORT_WORD with tx_last=1, tx_abort=1, tx_tag=grant; set err_timeout[grant]; advance ptr; go to IDLE.
    - Any later words from that requester up to and including its req_last arrive as a new packet; no resynchronisation is done.
- Simultaneous events:
  - If a timeout expires in the same cycle req_valid[grant] rises, the word wins and the counter clears.
  - If err_clear and a new timeout coincide, the flag stays set.
- Only one requester is ever granted. A single-word packet (valid and last in the first word) is legal.
- NUM_REQ=1 degenerates to a pass-through with a 1-cycle IDLE bubble per packet.
- Zero-length packets do not exist; every packet contains at least one word.
- Mid-packet reset: everything clears and the partial packet is dropped. Recovery is the requester's responsibility.
- Throughput: 1 word/cycle within a packet while the source is valid and tx_ready=1.

Decomposition:
- Shared package (pcileech_header): COM_TAG_WIDTH=2, typedef com_tag_t, and the requester index constants COM_REQ_TLP=0, COM_REQ_CFG=1, COM_REQ_CORE=2, COM_REQ_SHADOW=3.
- One sub-module: pcileech_rr_pick, a combinational rotate-priority search returning hit and index from (valid vector, ptr).
- Registers, the FSM and the timeout logic stay in the top of the block.

Test Plan:
- Three requesters valid together, each with a 2-word packet, ptr=0, tx_ready=1 → output tags 0,0,1,1,2,2 with last on the 2nd, 4th and 6th words, and a 1-cycle gap between packets.
- Req0 sends a 4-word packet while tx_ready toggles 1,0,0,1... → every word delivered once in order, tx_data stable during stalls, req_ready[0] low while tx_valid && !tx_ready.
- Req1 sends word A (last=0) then drops valid with TIMEOUT_CYCLES=8 → tx emits A, then 8 idle cycles, then DEADBEEF with last=1, abort=1, tag=1; err_timeout=3'b010; err_clear pulse → 0.
- Same stall but tx_ready held 0 for 20 cycles with req_valid high → no timeout, err_timeout stays 0.
- Req2 is mid-packet; req0 asserts a packet throughout → req0 is not granted until req2's last word; next grant goes to 0.
- rst_n asserted mid-packet (asynchronously, between clk edges) → tx_valid, req_ready and err_timeout drop immediately; after release the next packet starts from ptr=0.

Source files
------------

// File: rtl/pcileech_header.sv
// Shared COM definitions: source tag type, requester indices and arbiter helpers.
package pcileech_header;

  localparam int COM_TAG_WIDTH = 2;
  typedef logic [COM_TAG_WIDTH-1:0] com_tag_t;

  localparam com_tag_t COM_REQ_TLP    = 2'd0;
  localparam com_tag_t COM_REQ_CFG    = 2'd1;
  localparam com_tag_t COM_REQ_CORE   = 2'd2;
  localparam com_tag_t COM_REQ_SHADOW = 2'd3;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

  // Round-robin successor of idx among n requesters.
  function automatic com_tag_t rr_next(input com_tag_t idx, input int unsigned n);
    if (32'(idx) + 32'd1 >= n) return '0;
    return com_tag_t'(idx + 2'd1);
  endfunction

endpackage

// File: rtl/pcileech_rr_pick.sv
// Rotating-priority search: first set bit of valid_i starting at ptr_i, wrapping modulo N.
module pcileech_rr_pick
  import pcileech_header::*;
#(
  parameter int unsigned N = 3
) (
  input  logic [N-1:0] valid_i,
  input  com_tag_t     ptr_i,
  output logic         hit_o,
  output com_tag_t     idx_o
);

  // Outer loop is the distance from ptr, so the nearest requester wins.
  always_comb begin
    hit_o = 1'b0;
    idx_o = '0;
    for (int unsigned k = 0; k < N; k++) begin
      for (int unsigned j = 0; j < N; j++) begin
        if (!hit_o && valid_i[j] && (((32'(ptr_i) + k) % N) == j)) begin
          hit_o = 1'b1;
          idx_o = com_tag_t'(j);
        end
      end
    end
  end

endmodule

// File: rtl/pcileech_com_tx_arbiter.sv
// Packet-atomic round-robin arbiter sharing the COM TX word path among up to four
// requesters, with a registered output stage and a mid-packet stall timeout.
//
//   state    | meaning
//   ARB_IDLE | no grant held; pick next requester from ptr
//   ARB_BUSY | grant held; forward words until last or timeout
module pcileech_com_tx_arbiter
  import pcileech_header::*;
#(
  parameter int unsigned NUM_REQ        = 3,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] ABORT_WORD     = 32'hDEADBEEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [32*NUM_REQ-1:0]   req_data,
  input  logic [NUM_REQ-1:0]      req_last,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic                    tx_valid,
  output logic [31:0]             tx_data,
  output logic                    tx_last,
  output com_tag_t                tx_tag,
  output logic                    tx_abort,
  input  logic                    tx_ready,
  output logic [NUM_REQ-1:0]      err_timeout,
  input  logic                    err_clear
);

  localparam int unsigned      CNT_W   = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

  arb_state_e         state_q, state_d;
  com_tag_t           grant_q, grant_d;
  com_tag_t           ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               tx_valid_q, tx_valid_d;
  logic [31:0]        tx_data_q, tx_data_d;
  logic               tx_last_q, tx_last_d;
  com_tag_t           tx_tag_q, tx_tag_d;
  logic               tx_abort_q, tx_abort_d;
  logic [NUM_REQ-1:0] err_q, err_d;

  logic               out_free;
  logic [NUM_REQ-1:0] gnt_oh;
  logic               gnt_valid;
  logic               gnt_last;
  logic [31:0]        gnt_data;
  logic               accept;
  logic               pick_hit;
  com_tag_t           pick_idx;

  pcileech_rr_pick #(.N(NUM_REQ)) u_pick (
    .valid_i (req_valid),
    .ptr_i   (ptr_q),
    .hit_o   (pick_hit),
    .idx_o   (pick_idx)
  );

  always_comb begin
    gnt_oh   = '0;
    gnt_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      gnt_oh[i] = (grant_q == com_tag_t'(i));
      if (gnt_oh[i]) gnt_data = req_data[32*i +: 32];
    end
  end

  assign out_free  = !tx_valid_q || tx_ready;
  assign gnt_valid = |(req_valid & gnt_oh);
  assign gnt_last  = |(req_last & gnt_oh);
  assign accept    = (state_q == ARB_BUSY) && gnt_valid && out_free;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ARB_IDLE;
      grant_q    <= '0;
      ptr_q      <= '0;
      cnt_q      <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      tx_last_q  <= 1'b0;
      tx_tag_q   <= '0;
      tx_abort_q <= 1'b0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      tx_last_q  <= tx_last_d;
      tx_tag_q   <= tx_tag_d;
      tx_abort_q <= tx_abort_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    tx_last_d  = tx_last_q;
    tx_tag_d   = tx_tag_q;
    tx_abort_d = tx_abort_q;
    // Clear is applied first so a coincident timeout still leaves its flag set.
    err_d      = err_q & ~{NUM_REQ{err_clear}};

    if (out_free) tx_valid_d = 1'b0;

    unique case (state_q)
      ARB_IDLE: begin
        if (pick_hit) begin
          grant_d = pick_idx;
          cnt_d   = '0;
          state_d = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        if (accept) begin
          tx_valid_d = 1'b1;
          tx_data_d  = gnt_data;
          tx_last_d  = gnt_last;
          tx_tag_d   = grant_q;
          tx_abort_d = 1'b0;
          cnt_d      = '0;
          if (gnt_last) begin
            ptr_d   = rr_next(grant_q, NUM_REQ);
            state_d = ARB_IDLE;
          end
        end else if (!gnt_valid && (TIMEOUT_CYCLES != 0)) begin
          // Counter saturates at the limit and waits for room in the output stage.
          if (cnt_q == CNT_MAX) begin
            if (out_free) begin
              tx_valid_d = 1'b1;
              tx_data_d  = ABORT_WORD;
              tx_last_d  = 1'b1;
              tx_tag_d   = grant_q;
              tx_abort_d = 1'b1;
              err_d      = err_d | gnt_oh;
              ptr_d      = rr_next(grant_q, NUM_REQ);
              state_d    = ARB_IDLE;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    if (state_q == ARB_BUSY && out_free) req_ready = req_valid & gnt_oh;
  end

  assign tx_valid    = tx_valid_q;
  assign tx_data     = tx_data_q;
  assign tx_last     = tx_last_q;
  assign tx_tag      = tx_tag_q;
  assign tx_abort    = tx_abort_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_pcileech_com_tx_arbiter.sv
// Self-checking bench for pcileech_com_tx_arbiter: vector table, directed corner
// sequences and a randomized run scored against per-requester word queues.
module tb_pcileech_com_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  req_valid = '0;
  logic [95:0] req_data = '0;
  logic [2:0]  req_last = '0;
  logic [2:0]  req_ready;
  logic        tx_valid;
  logic [31:0] tx_data;
  logic        tx_last;
  logic [1:0]  tx_tag;
  logic        tx_abort;
  logic        tx_ready = 1'b0;
  logic [2:0]  err_timeout;
  logic        err_clear = 1'b0;

  int errors = 0;
  int checks = 0;

  pcileech_com_tx_arbiter #(
    .NUM_REQ        (3),
    .TIMEOUT_CYCLES (8),
    .ABORT_WORD     (32'hDEADBEEF)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .tx_valid    (tx_valid),
    .tx_data     (tx_data),
    .tx_last     (tx_last),
    .tx_tag      (tx_tag),
    .tx_abort    (tx_abort),
    .tx_ready    (tx_ready),
    .err_timeout (err_timeout),
    .err_clear   (err_clear)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    logic [2:0] v;
    logic [2:0] l;
    logic [2:0] exp_rdy;
    logic       exp_txv;
    logic [1:0] exp_tag;
    logic       exp_last;
  } vec_t;

  vec_t tbl[11];

  logic [32:0] expq[3][$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic set_word(input int r, input logic [31:0] d, input logic l);
    req_data[32*r +: 32] = d;
    req_last[r] = l;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req_valid = '0;
    req_last = '0;
    req_data = '0;
    tx_ready = 1'b0;
    err_clear = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Drives one packet of n random words on requester r while others stay valid,
  // checking order, tag, hold-under-stall and exclusive grant.
  // mode 0: tx_ready = 1,0,0,1,0,0...; mode 1: tx_ready low for the first stall cycles.
  task automatic run_pkt(input int r, input int n, input int mode, input int stall,
                         input logic [2:0] others, input string nm);
    logic [31:0] w[$];
    int idx = 0;
    int nrx = 0;
    logic prev_stall = 1'b0;
    logic [31:0] prev_data = '0;
    for (int k = 0; k < n; k++) w.push_back($urandom);
    for (int c = 0; c < 200 && nrx < n; c++) begin
      @(negedge clk);
      tx_ready = (mode == 0) ? (c % 3 == 0) : (c >= stall);
      req_valid = others;
      for (int o = 0; o < 3; o++)
        if (others[o]) set_word(o, 32'h0BAD_0000 | o, 1'b0);
      if (idx < n) begin
        req_valid[r] = 1'b1;
        set_word(r, w[idx], idx == n - 1);
      end
      #1;
      if (prev_stall) begin
        chk({nm, "_hold_data"}, tx_data, prev_data);
        chk({nm, "_hold_valid"}, 32'(tx_valid), 1);
      end
      if (tx_valid && !tx_ready) chk({nm, "_rdy_stall"}, 32'(req_ready), 0);
      chk({nm, "_rdy_other"}, 32'(req_ready & ~(3'b001 << r)), 0);
      if (tx_valid && tx_ready) begin
        chk({nm, "_data"}, tx_data, w[nrx]);
        chk({nm, "_last"}, 32'(tx_last), 32'(nrx == n - 1));
        chk({nm, "_tag"}, 32'(tx_tag), r);
        chk({nm, "_abort"}, 32'(tx_abort), 0);
        nrx++;
      end
      prev_stall = tx_valid && !tx_ready;
      prev_data = tx_data;
      if (req_ready[r]) idx++;
    end
    chk({nm, "_count"}, nrx, n);
    req_valid = others;
  endtask

  initial begin
    logic seen;
    int idle;
    logic a_acc;
    logic got_a;
    int pkt_rem[3];
    logic have[3];
    int gap[3];
    logic [31:0] cw[3];
    logic cl[3];
    logic acc_prev[3];
    int open_tag;
    int nxfer;
    logic prev_stall;
    logic [36:0] prev_ctl;
    logic [32:0] e;

    // {valid, last, exp ready, exp tx_valid, exp tag, exp last}
    tbl[0]  = '{3'b111, 3'b000, 3'b000, 1'b0, 2'd0, 1'b0};
    tbl[1]  = '{3'b111, 3'b000, 3'b001, 1'b0, 2'd0, 1'b0};
    tbl[2]  = '{3'b111, 3'b001, 3'b001, 1'b1, 2'd0, 1'b0};
    tbl[3]  = '{3'b111, 3'b000, 3'b000, 1'b1, 2'd0, 1'b1};
    tbl[4]  = '{3'b111, 3'b000, 3'b010, 1'b0, 2'd0, 1'b0};
    tbl[5]  = '{3'b111, 3'b010, 3'b010, 1'b1, 2'd1, 1'b0};
    tbl[6]  = '{3'b111, 3'b000, 3'b000, 1'b1, 2'd1, 1'b1};
    tbl[7]  = '{3'b111, 3'b000, 3'b100, 1'b0, 2'd0, 1'b0};
    tbl[8]  = '{3'b111, 3'b100, 3'b100, 1'b1, 2'd2, 1'b0};
    tbl[9]  = '{3'b000, 3'b000, 3'b000, 1'b1, 2'd2, 1'b1};
    tbl[10] = '{3'b000, 3'b000, 3'b000, 1'b0, 2'd0, 1'b0};

    // Reset values
    rst_n = 1'b0;
    #3;
    chk("rst_tx_valid", 32'(tx_valid), 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_tx_last", 32'(tx_last), 0);
    chk("rst_tx_tag", 32'(tx_tag), 0);
    chk("rst_tx_abort", 32'(tx_abort), 0);
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_err", 32'(err_timeout), 0);
    do_reset();

    // Three 2-word packets, round robin from ptr=0 with one bubble between packets
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      tx_ready = 1'b1;
      req_valid = tbl[i].v;
      for (int r = 0; r < 3; r++) set_word(r, {4'(r + 1), 28'(i)}, tbl[i].l[r]);
      #1;
      chk($sformatf("tbl%0d_ready", i), 32'(req_ready), 32'(tbl[i].exp_rdy));
      chk($sformatf("tbl%0d_txv", i), 32'(tx_valid), 32'(tbl[i].exp_txv));
      if (tbl[i].exp_txv) begin
        chk($sformatf("tbl%0d_tag", i), 32'(tx_tag), 32'(tbl[i].exp_tag));
        chk($sformatf("tbl%0d_last", i), 32'(tx_last), 32'(tbl[i].exp_last));
        chk($sformatf("tbl%0d_data", i), tx_data, {4'(tbl[i].exp_tag + 2'd1), 28'(i - 1)});
      end
    end

    // Req0 4-word packet under toggling backpressure
    run_pkt(0, 4, 0, 0, 3'b000, "bp");

    // Req1 stalls mid-packet: abort after 8 idle cycles
    @(negedge clk);
    tx_ready = 1'b1;
    req_valid = 3'b010;
    set_word(1, 32'hA5A5_0001, 1'b0);
    a_acc = 1'b0; got_a = 1'b0; idle = 0; seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      if (c > 0) @(negedge clk);
      if (a_acc) req_valid = 3'b000;
      #1;
      if (tx_valid) begin
        if (!got_a) begin
          chk("to_word_a", tx_data, 32'hA5A5_0001);
          chk("to_word_a_abort", 32'(tx_abort), 0);
          got_a = 1'b1;
        end else begin
          chk("to_abort_data", tx_data, 32'hDEADBEEF);
          chk("to_abort_last", 32'(tx_last), 1);
          chk("to_abort_flag", 32'(tx_abort), 1);
          chk("to_abort_tag", 32'(tx_tag), 1);
          seen = 1'b1;
        end
      end else if (got_a) begin
        idle++;
      end
      if (req_ready[1]) a_acc = 1'b1;
    end
    chk("to_seen", 32'(seen), 1);
    chk("to_idle_cycles", idle, 8);
    chk("to_err", 32'(err_timeout), 32'b010);
    @(negedge clk);
    err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;
    #1;
    chk("to_err_cleared", 32'(err_timeout), 0);

    // Long downstream stall with valid high must not time out
    run_pkt(1, 2, 1, 20, 3'b000, "bp20");
    chk("bp20_err", 32'(err_timeout), 0);

    // Req2 holds the grant while req0 waits; req0 is next
    run_pkt(2, 3, 1, 0, 3'b001, "mid");
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      tx_ready = 1'b1;
      #1;
      if (tx_valid) begin
        chk("mid_next_tag", 32'(tx_tag), 0);
        seen = 1'b1;
      end
    end
    chk("mid_next_seen", 32'(seen), 1);

    // Req0 now stalls mid-packet -> abort tagged 0
    @(negedge clk);
    req_valid = 3'b000;
    seen = 1'b0;
    for (int c = 0; c < 30 && !seen; c++) begin
      @(negedge clk);
      #1;
      if (tx_valid && tx_abort) begin
        chk("to0_tag", 32'(tx_tag), 0);
        chk("to0_data", tx_data, 32'hDEADBEEF);
        seen = 1'b1;
      end
    end
    chk("to0_seen", 32'(seen), 1);
    chk("to0_err", 32'(err_timeout), 32'b001);

    // Async reset mid-packet of req1 while output is stalled
    @(negedge clk);
    tx_ready = 1'b0;
    req_valid = 3'b010;
    set_word(1, 32'h1111_0001, 1'b0);
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      #1;
      if (req_ready[1]) seen = 1'b1;
      else @(negedge clk);
    end
    chk("rst_mid_accept", 32'(seen), 1);
    @(posedge clk);
    #2;
    chk("rst_pre_txv", 32'(tx_valid), 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_txv", 32'(tx_valid), 0);
    chk("rst_mid_ready", 32'(req_ready), 0);
    chk("rst_mid_err", 32'(err_timeout), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    req_valid = 3'b111;
    for (int r = 0; r < 3; r++) set_word(r, 32'h2222_0000 | r, 1'b1);
    tx_ready = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      #1;
      if (tx_valid) begin
        chk("rst_first_tag", 32'(tx_tag), 0);
        chk("rst_first_data", tx_data, 32'h2222_0000);
        seen = 1'b1;
      end
    end
    chk("rst_first_seen", 32'(seen), 1);

    // Randomized traffic scored per requester
    do_reset();
    for (int r = 0; r < 3; r++) begin
      pkt_rem[r] = 0; have[r] = 1'b0; gap[r] = 0; cw[r] = '0; cl[r] = 1'b0;
      acc_prev[r] = 1'b0;
      expq[r].delete();
    end
    open_tag = -1;
    nxfer = 0;
    prev_stall = 1'b0;
    prev_ctl = '0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      for (int r = 0; r < 3; r++) begin
        if (acc_prev[r]) begin
          have[r] = 1'b0;
          gap[r] = cl[r] ? int'($urandom_range(0, 5)) : int'($urandom_range(0, 2));
        end
        if (!have[r]) begin
          if (gap[r] > 0) gap[r]--;
          else if (pkt_rem[r] > 0 || c < 3000) begin
            if (pkt_rem[r] == 0) pkt_rem[r] = int'($urandom_range(1, 4));
            cw[r] = $urandom;
            cl[r] = (pkt_rem[r] == 1);
            pkt_rem[r]--;
            have[r] = 1'b1;
            expq[r].push_back({cl[r], cw[r]});
          end
        end
        req_valid[r] = have[r];
        set_word(r, cw[r], cl[r]);
      end
      tx_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (prev_stall) begin
        chk("rnd_hold_data", tx_data, prev_ctl[31:0]);
        chk("rnd_hold_ctl", 32'(prev_ctl[36:32]), 32'({tx_valid, tx_last, tx_tag, tx_abort}));
      end
      chk("rnd_ready_rules",
          32'(($countones(req_ready) > 1) || ((req_ready & ~req_valid) != 0) ||
              (req_ready != 0 && tx_valid && !tx_ready)), 0);
      if (tx_valid && tx_ready) begin
        chk("rnd_abort", 32'(tx_abort), 0);
        if (open_tag >= 0) chk("rnd_atomic", 32'(tx_tag), open_tag);
        if (tx_tag > 2'd2 || expq[tx_tag].size() == 0) begin
          chk("rnd_unexpected_word", 32'(tx_tag), 32'hFFFF_FFFF);
        end else begin
          e = expq[tx_tag].pop_front();
          chk("rnd_data", tx_data, e[31:0]);
          chk("rnd_last", 32'(tx_last), 32'(e[32]));
        end
        open_tag = tx_last ? -1 : int'(tx_tag);
        nxfer++;
      end
      for (int r = 0; r < 3; r++) acc_prev[r] = req_ready[r];
      prev_stall = tx_valid && !tx_ready;
      prev_ctl = {tx_valid, tx_last, tx_tag, tx_abort, tx_data};
    end
    chk("rnd_drained", 32'(expq[0].size() + expq[1].size() + expq[2].size()), 0);
    chk("rnd_no_timeout", 32'(err_timeout), 0);
    chk("rnd_traffic", 32'(nxfer > 500), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
